// File: rtl/dac_wave_sequencer_if.sv
// -----------------------------------------------------------------------------
// dac_wave_sequencer_if
//
// Bundles the configuration/control inputs and the waveform-datapath outputs
// of dac_wave_sequencer. Clock and reset are kept as plain module ports.
//
//   cfg_we, cfg_idx, cfg_data  segment slot write (ignored while busy)
//   start, stop, loop          playback control levels
//   tbl_sel, tbl_addr          table select / address to the lookup stage
//   sample_valid               tbl_sel/tbl_addr carry a live sample
//   seg_idx                    segment currently loaded or playing
//   busy, done                 sequence in progress / one-cycle end pulse
//
// modport master : the controller side (drives cfg/control, observes outputs)
// modport slave  : the sequencer itself
//
// ADDR_W and SEG_N must match the parameters given to dac_wave_sequencer.
// -----------------------------------------------------------------------------
interface dac_wave_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int SEG_N  = 4
);
  localparam int IDX_W = $clog2(SEG_N);

  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [15:0]       cfg_data;
  logic              start;
  logic              stop;
  logic              loop;

  logic [1:0]        tbl_sel;
  logic [ADDR_W-1:0] tbl_addr;
  logic              sample_valid;
  logic [IDX_W-1:0]  seg_idx;
  logic              busy;
  logic              done;

  modport master (
    output cfg_we, cfg_idx, cfg_data, start, stop, loop,
    input  tbl_sel, tbl_addr, sample_valid, seg_idx, busy, done
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_data, start, stop, loop,
    output tbl_sel, tbl_addr, sample_valid, seg_idx, busy, done
  );
endinterface

// File: rtl/dac_wave_sequencer.sv
// -----------------------------------------------------------------------------
// dac_wave_sequencer
//
// Playlist scheduler for the dual-DAC waveform datapath. Holds SEG_N segment
// slots (table select, address step, last flag, repeat count) and plays them
// back in order, driving the table select/address of the lookup stage.
//
// Ports:
//   clk    system clock, all logic on the rising edge
//   rst_n  asynchronous active-low reset (also clears the segment slots)
//   bus    dac_wave_sequencer_if.slave, see the interface for signal list
//
// cfg_data layout (CNT_W = 8):
//   [15:14] wave_sel  [13:11] step  [10] last  [9:2] repeats  [1:0] reserved
// A step of 0 plays as 1; repeats of 0 plays 2^CNT_W periods.
// -----------------------------------------------------------------------------
module dac_wave_sequencer #(
  parameter int ADDR_W = 5,
  parameter int SEG_N  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dac_wave_sequencer_if.slave  bus
);
  localparam int IDX_W = $clog2(SEG_N);
  // Stored slot word: {wave_sel[1:0], step[2:0], last, repeats[CNT_W-1:0]}
  localparam int SEG_W = 6 + CNT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t            state_reg,        state_next;
  logic [IDX_W-1:0]  seg_idx_reg,      seg_idx_next;
  logic              stop_pending_reg, stop_pending_next;
  logic [ADDR_W-1:0] tbl_addr_reg,     tbl_addr_next;
  logic [1:0]        tbl_sel_reg,      tbl_sel_next;
  logic              sample_valid_reg, sample_valid_next;
  logic              busy_reg,         busy_next;
  logic              done_reg,         done_next;
  logic [2:0]        step_reg,         step_next;
  logic              last_reg,         last_next;
  logic [CNT_W-1:0]  rep_cnt_reg,      rep_cnt_next;

  // ---------------------------------------------------------------------------
  // Segment slots. Writes are only accepted in IDLE, which also covers a write
  // coinciding with an accepted start: LOAD then sees the new word.
  // ---------------------------------------------------------------------------
  logic              cfg_wr_en;
  logic [SEG_W-1:0]  cfg_word;
  logic [SEG_W-1:0]  slot_words [SEG_N];
  logic              unused_cfg_bits;

  assign cfg_wr_en       = bus.cfg_we && (state_reg == IDLE);
  assign cfg_word        = bus.cfg_data[2 +: SEG_W];
  assign unused_cfg_bits = ^bus.cfg_data[1:0];

  genvar gi;
  generate
    for (gi = 0; gi < SEG_N; gi++) begin : g_slot
      logic [SEG_W-1:0] slot_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_reg <= '0;
        end else if (cfg_wr_en && (bus.cfg_idx == IDX_W'(gi))) begin
          slot_reg <= cfg_word;
        end
      end

      assign slot_words[gi] = slot_reg;
    end
  endgenerate

  // Decoded view of the slot addressed by seg_idx (used during LOAD).
  logic [SEG_W-1:0] cur_seg;
  logic [1:0]       cur_sel;
  logic [2:0]       cur_step;
  logic             cur_last;
  logic [CNT_W-1:0] cur_reps;

  assign cur_seg  = slot_words[seg_idx_reg];
  assign cur_sel  = cur_seg[CNT_W+5:CNT_W+4];
  assign cur_step = (cur_seg[CNT_W+3:CNT_W+1] == 3'd0) ? 3'd1 : cur_seg[CNT_W+3:CNT_W+1];
  assign cur_last = cur_seg[CNT_W];
  // repeats of 0 needs no special case: decrementing from 0 wraps, so the
  // counter reaches 1 only after 2^CNT_W - 1 period boundaries.
  assign cur_reps = cur_seg[CNT_W-1:0];

  // One extra bit so the carry out marks a period boundary while the low bits
  // keep the phase across the wrap.
  logic [ADDR_W:0] addr_sum;
  logic            addr_carry;

  assign addr_sum   = {1'b0, tbl_addr_reg} + (ADDR_W+1)'(step_reg);
  assign addr_carry = addr_sum[ADDR_W];

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    seg_idx_next      = seg_idx_reg;
    stop_pending_next = stop_pending_reg;
    tbl_addr_next     = tbl_addr_reg;
    tbl_sel_next      = tbl_sel_reg;
    sample_valid_next = 1'b0;
    busy_next         = busy_reg;
    done_next         = 1'b0;
    step_next         = step_reg;
    last_next         = last_reg;
    rep_cnt_next      = rep_cnt_reg;

    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        // stop has priority over a simultaneous start
        if (bus.start && !bus.stop) begin
          state_next        = LOAD;
          seg_idx_next      = '0;
          stop_pending_next = 1'b0;
          tbl_addr_next     = '0;
          busy_next         = 1'b1;
        end
      end

      LOAD: begin
        stop_pending_next = stop_pending_reg | bus.stop;
        tbl_sel_next      = cur_sel;
        step_next         = cur_step;
        last_next         = cur_last;
        rep_cnt_next      = cur_reps;
        tbl_addr_next     = '0;
        sample_valid_next = 1'b1;
        busy_next         = 1'b1;
        state_next        = RUN;
      end

      RUN: begin
        stop_pending_next = stop_pending_reg | bus.stop;
        sample_valid_next = 1'b1;
        busy_next         = 1'b1;
        tbl_addr_next     = addr_sum[ADDR_W-1:0];

        if (addr_carry) begin
          if (stop_pending_reg) begin
            // Graceful stop: only ever taken on a period boundary.
            state_next        = IDLE;
            sample_valid_next = 1'b0;
            busy_next         = 1'b0;
            done_next         = 1'b1;
            tbl_addr_next     = '0;
          end else if (rep_cnt_reg != CNT_W'(1)) begin
            rep_cnt_next = rep_cnt_reg - 1'b1;
          end else if (!last_reg && (seg_idx_reg != IDX_W'(SEG_N-1))) begin
            seg_idx_next      = seg_idx_reg + 1'b1;
            state_next        = LOAD;
            sample_valid_next = 1'b0;
            tbl_addr_next     = '0;
          end else if (bus.loop) begin
            seg_idx_next      = '0;
            state_next        = LOAD;
            sample_valid_next = 1'b0;
            tbl_addr_next     = '0;
          end else begin
            state_next        = IDLE;
            sample_valid_next = 1'b0;
            busy_next         = 1'b0;
            done_next         = 1'b1;
            tbl_addr_next     = '0;
          end
        end
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      seg_idx_reg      <= '0;
      stop_pending_reg <= 1'b0;
      tbl_addr_reg     <= '0;
      tbl_sel_reg      <= 2'd0;
      sample_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      step_reg         <= 3'd0;
      last_reg         <= 1'b0;
      rep_cnt_reg      <= '0;
    end else begin
      state_reg        <= state_next;
      seg_idx_reg      <= seg_idx_next;
      stop_pending_reg <= stop_pending_next;
      tbl_addr_reg     <= tbl_addr_next;
      tbl_sel_reg      <= tbl_sel_next;
      sample_valid_reg <= sample_valid_next;
      busy_reg         <= busy_next;
      done_reg         <= done_next;
      step_reg         <= step_next;
      last_reg         <= last_next;
      rep_cnt_reg      <= rep_cnt_next;
    end
  end

  assign bus.tbl_sel      = tbl_sel_reg;
  assign bus.tbl_addr     = tbl_addr_reg;
  assign bus.sample_valid = sample_valid_reg;
  assign bus.seg_idx      = seg_idx_reg;
  assign bus.busy         = busy_reg;
  assign bus.done         = done_reg;

endmodule

// File: tb/tb_dac_wave_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dac_wave_sequencer
//
// Scoreboard bench: each started sequence is expanded by a playlist model into
// the list of samples and the final done pulse it must produce, each tagged
// with the clock cycle it belongs to. A monitor on the falling edge pops and
// compares an entry whenever the sequencer shows sample_valid or done.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dac_wave_sequencer;
  localparam int ADDR_W = 5;
  localparam int SEG_N  = 4;
  localparam int CNT_W  = 8;
  localparam int PERIOD = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  dac_wave_sequencer_if #(.ADDR_W(ADDR_W), .SEG_N(SEG_N)) bus ();

  dac_wave_sequencer #(.ADDR_W(ADDR_W), .SEG_N(SEG_N), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          is_done;
    logic [1:0]  sel;
    logic [4:0]  addr;
    logic [1:0]  seg;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] ram_m [SEG_N];
  int          edge_n = 0;
  int          checks = 0;
  int          errors = 0;
  int          seq_n  = 0;

  // edge_n = number of rising edges so far; "cycle n" is the time after edge n
  always @(posedge clk) edge_n <= edge_n + 1;

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : monitor
    ev_t e;
    if (rst_n && (bus.sample_valid || bus.done)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cyc=%0d valid=%0b done=%0b sel=%0d addr=%0d seg=%0d",
                 edge_n, bus.sample_valid, bus.done, bus.tbl_sel, bus.tbl_addr, bus.seg_idx);
      end else begin
        e = exp_q.pop_front();
        if ((e.cyc != edge_n) || (bus.done !== e.is_done) ||
            (bus.sample_valid !== ~e.is_done) || (bus.busy !== ~e.is_done) ||
            (bus.tbl_sel !== e.sel) || (bus.tbl_addr !== e.addr) || (bus.seg_idx !== e.seg)) begin
          errors++;
          $display("FAIL out_event got(cyc=%0d valid=%0b done=%0b busy=%0b sel=%0d addr=%0d seg=%0d) expected(cyc=%0d done=%0b sel=%0d addr=%0d seg=%0d)",
                   edge_n, bus.sample_valid, bus.done, bus.busy, bus.tbl_sel, bus.tbl_addr,
                   bus.seg_idx, e.cyc, e.is_done, e.sel, e.addr, e.seg);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] mk(input int sel, input int stp, input bit last, input int reps);
    logic [15:0] w;
    w        = '0;
    w[15:14] = 2'(sel);
    w[13:11] = 3'(stp);
    w[10]    = last;
    w[9:2]   = 8'(reps);
    return w;
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w      = mk($urandom_range(0, 3), $urandom_range(0, 7), ($urandom_range(0, 2) == 0),
                $urandom_range(1, 3));
    w[1:0] = 2'($urandom_range(0, 3));
    return w;
  endfunction

  function automatic void push_ev(input int cyc, input bit d, input logic [1:0] sel,
                                  input int addr, input int seg);
    ev_t e;
    e.cyc     = cyc;
    e.is_done = d;
    e.sel     = sel;
    e.addr    = 5'(addr);
    e.seg     = 2'(seg);
    exp_q.push_back(e);
  endfunction

  task automatic check_eq(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tbl_sel"},      int'(bus.tbl_sel),      0);
    check_eq({tag, "_tbl_addr"},     int'(bus.tbl_addr),     0);
    check_eq({tag, "_sample_valid"}, int'(bus.sample_valid), 0);
    check_eq({tag, "_seg_idx"},      int'(bus.seg_idx),      0);
    check_eq({tag, "_busy"},         int'(bus.busy),         0);
    check_eq({tag, "_done"},         int'(bus.done),         0);
  endtask

  // Playlist model. k is the edge at which start is sampled; cycle k is LOAD.
  // stop_edge (or -1) is the edge at which stop is sampled while busy; any
  // period boundary reached after it ends the sequence.
  task automatic build_expect(input int k, input bit lp, input int stop_edge);
    int         cyc, s, addr, stp, reps, nxt, n;
    bit         last, ended;
    logic [1:0] sel;
    cyc   = k;
    s     = 0;
    ended = 0;
    while (!ended) begin
      sel  = ram_m[s][15:14];
      stp  = int'(ram_m[s][13:11]);
      if (stp == 0) stp = 1;
      last = ram_m[s][10];
      reps = int'(ram_m[s][9:2]);
      if (reps == 0) reps = 1 << CNT_W;
      cyc++;                      // LOAD cycle consumed, first sample next
      addr = 0;
      while (reps > 0 && !ended) begin
        push_ev(cyc, 1'b0, sel, addr, s);
        n    = cyc;
        cyc++;
        nxt  = addr + stp;
        addr = nxt % PERIOD;
        if (nxt >= PERIOD) begin
          if (stop_edge >= 0 && n >= stop_edge) begin
            push_ev(cyc, 1'b1, sel, 0, s);
            ended = 1;
          end else begin
            reps--;
          end
        end
      end
      if (!ended) begin
        if (!last && s != SEG_N - 1) s++;
        else if (lp) s = 0;
        else begin
          push_ev(cyc, 1'b1, sel, 0, s);
          ended = 1;
        end
      end
      if (exp_q.size() > 50000) ended = 1;
    end
  endtask

  task automatic cfg_write(input int idx, input logic [15:0] data);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = 2'(idx);
    bus.cfg_data = data;
    ram_m[idx]   = data;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  // Start one sequence, drive the optional stop / in-run write, wait for the
  // scoreboard to drain, then confirm the sequencer is idle.
  task automatic run_seq(input bit lp, input int stop_rel, input bit wr_start, input int wr_idx,
                         input logic [15:0] wr_data, input int run_wr_rel,
                         input logic [15:0] run_wr_data);
    int k, budget;
    bit drained;
    @(negedge clk);
    k = edge_n + 1;
    if (wr_start) begin
      ram_m[wr_idx] = wr_data;
      bus.cfg_we    = 1'b1;
      bus.cfg_idx   = 2'(wr_idx);
      bus.cfg_data  = wr_data;
    end
    build_expect(k, lp, (stop_rel > 0) ? k + stop_rel : -1);
    budget = exp_q[$].cyc - k + 20;
    seq_n++;
    $display("seq %0d: start_edge=%0d loop=%0b stop_rel=%0d run_wr_rel=%0d events=%0d",
             seq_n, k, lp, stop_rel, run_wr_rel, exp_q.size());
    bus.loop  = lp;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
    drained    = 0;
    for (int i = 0; i < budget; i++) begin
      bus.stop     = (stop_rel > 0) && (edge_n + 1 == k + stop_rel);
      bus.cfg_we   = (run_wr_rel > 0) && (edge_n + 1 == k + run_wr_rel);
      bus.cfg_idx  = '0;
      bus.cfg_data = run_wr_data;
      @(negedge clk);
      if (exp_q.size() == 0) begin
        drained = 1;
        break;
      end
    end
    bus.stop   = 1'b0;
    bus.cfg_we = 1'b0;
    if (!drained) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout seq=%0d remaining=%0d required=0", seq_n, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    @(negedge clk);
    check_eq("post_seq_busy", int'(bus.busy), 0);
    bus.loop = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int         k, wi, stop_rel, run_wr_rel;
    bit         lp;
    logic [15:0] w;

    bus.cfg_we   = 1'b0;
    bus.cfg_idx  = '0;
    bus.cfg_data = '0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.loop     = 1'b0;
    for (int s = 0; s < SEG_N; s++) ram_m[s] = '0;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");

    // Single segment: 32 samples of table 1, then done
    cfg_write(0, mk(1, 1, 1, 1));
    run_seq(1'b0, -1, 1'b0, 0, '0, -1, '0);

    // Step 3, two periods: phase carries across the wrap
    cfg_write(0, mk(2, 3, 1, 2));
    run_seq(1'b0, -1, 1'b0, 0, '0, -1, '0);

    // Two segments with one LOAD gap between them
    cfg_write(0, mk(0, 4, 0, 1));
    cfg_write(1, mk(3, 2, 1, 1));
    run_seq(1'b0, -1, 1'b0, 0, '0, -1, '0);

    // Graceful stop sampled while tbl_addr=10 (first sample is cycle k+1)
    cfg_write(0, mk(0, 1, 1, 5));
    run_seq(1'b0, 12, 1'b0, 0, '0, -1, '0);

    // start together with stop in IDLE must not start anything
    @(negedge clk);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check_eq("start_stop_idle_busy", int'(bus.busy), 0);
    repeat (2) begin
      @(negedge clk);
      check_eq("start_stop_idle_busy", int'(bus.busy), 0);
    end

    // Loop with a write attempted during RUN; stop ends the third pass
    cfg_write(0, mk(1, 4, 1, 1));
    run_seq(1'b1, 20, 1'b0, 0, '0, 5, mk(2, 7, 1, 3));
    // Slot 0 must still hold the pre-run word
    run_seq(1'b0, -1, 1'b0, 0, '0, -1, '0);

    // Write on the start cycle is seen by LOAD
    run_seq(1'b0, -1, 1'b1, 0, mk(3, 5, 1, 1), -1, '0);

    // Randomized playlists
    for (int t = 0; t < 20; t++) begin
      wi = $urandom_range(0, SEG_N - 1);
      for (int s = 0; s < SEG_N; s++) begin
        if (s != wi) cfg_write(s, rand_word());
      end
      lp = 1'($urandom_range(0, 1));
      if (lp) stop_rel = $urandom_range(1, 150);
      else    stop_rel = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 100)) : -1;
      run_wr_rel = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 5)) : -1;
      w = rand_word();
      run_seq(lp, stop_rel, 1'b1, wi, w, run_wr_rel, rand_word());
    end

    // Asynchronous reset in the middle of RUN
    cfg_write(0, mk(2, 1, 1, 10));
    @(negedge clk);
    k = edge_n + 1;
    build_expect(k, 1'b0, -1);
    seq_n++;
    $display("seq %0d: start_edge=%0d reset_abort events=%0d", seq_n, k, exp_q.size());
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    #3;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    for (int s = 0; s < SEG_N; s++) ram_m[s] = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("held_reset");
    rst_n = 1'b1;

    // Cleared slots: 4 segments x 256 periods of step 1, table 0
    run_seq(1'b0, -1, 1'b0, 0, '0, -1, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_wave_sequencer.md
# dac_wave_sequencer

Playlist scheduler for the AD9763 dual-DAC waveform datapath. It holds up to SEG_N programmable segments, each with a table select, address step, repeat count and last flag, and plays them back in order. During playback it drives the table-select and table-address inputs of the waveform lookup/DAC stage, replacing free-running address counting with a sequenced, start/stop-controlled schedule.

## Interface
- ADDR_W, 5, table address width; a table period is 2^ADDR_W entries.
- SEG_N, 4, number of segment slots (power of two, 2..16).
- CNT_W, 8, repeat-count width.
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  segment write strobe; ignored while busy=1.
- cfg_idx  in  log2(SEG_N)  segment slot written.
- cfg_data  in  16  [15:14] wave_sel, [13:11] step, [10] last, [9:2] repeats (CNT_W=8), [1:0] reserved.
- start  in  1  level-sampled start request.
- stop  in  1  graceful stop request.
- loop  in  1  restart at segment 0 after the final segment.
- tbl_sel  out  2  table select to the waveform datapath.
- tbl_addr  out  ADDR_W  table address to the waveform datapath.
- sample_valid  out  1  tbl_sel/tbl_addr are a live sample.
- seg_idx  out  log2(SEG_N)  segment currently loaded or playing.
- busy  out  1  sequence in progress (LOAD or RUN).
- done  out  1  one-cycle pulse when a sequence ends.

## Operation
- Segment RAM: SEG_N x 14-bit registers. Reset clears every slot to 0. The decoded reset contents are wave_sel 0, step 1, last 0 and repeats 256.
- step field 0 is treated as 1. repeats field 0 means 2^CNT_W periods.
- FSM states are IDLE, LOAD and RUN.
- IDLE -> LOAD when start=1 and stop=0. On entry, seg_idx <= 0, stop_pending <= 0, tbl_addr <= 0.
- LOAD lasts 1 cycle. It latches wave_sel, step and last of slot seg_idx into working registers and rep_cnt <= repeats. tbl_addr is 0. sample_valid is 0.
- RUN: sample_valid=1 and tbl_sel=wave_sel. Each cycle, next = tbl_addr + step computed in ADDR_W+1 bits. tbl_addr <= next[ADDR_W-1:0], so phase continues across a wrap.
- A carry (next[ADDR_W]=1) marks a period boundary. On a carry:
  - If stop_pending: go to IDLE.
  - Else if rep_cnt != 1: rep_cnt decrements.
  - Else, segment complete:
    - If last=0 and seg_idx != SEG_N-1: seg_idx++, go to LOAD, tbl_addr <= 0.
    - Else if loop=1: seg_idx <= 0, go to LOAD, tbl_addr <= 0.
    - Else: go to IDLE.
- stop=1 in LOAD or RUN sets stop_pending. The sequence ends only at the next carry, so a period is never truncated.
- On entry to IDLE from RUN: done=1 for one cycle, busy=0, sample_valid=0, tbl_addr <= 0. tbl_sel and seg_idx hold their values.
- start while busy is ignored. start and stop together in IDLE: stop wins, the FSM stays in IDLE.
- A cfg_we in the same cycle as an accepted start still writes. The new value is seen by LOAD.

## Timing
- Reset values: tbl_sel 0, tbl_addr 0, sample_valid 0, seg_idx 0, busy 0, done 0, FSM IDLE, stop_pending 0, rep_cnt 0.
- All outputs are registered.
- start sampled high at edge k:
  - Cycle k+1: LOAD, busy=1.
  - Cycle k+2: first valid sample, tbl_addr=0.
- Latency from segment end to the next segment's first sample is 2 cycles: 1 LOAD gap cycle with sample_valid=0.
- done asserts the cycle after the final carry cycle, together with busy=0.
- The datapath samples tbl_addr on the opposite clock edge. Outputs are stable for a full cycle.
- rst_n asserted mid-sequence clears everything immediately, including segment RAM. No done pulse is produced.

## Test plan
- Reset: assert rst_n=0 mid-RUN -> all outputs at reset values asynchronously. After release, a start with unwritten RAM plays wave_sel 0, step 1, for 256 periods in each of slots 0..3 (SEG_N=4), then done.
- Single segment: slot0 = sel 1, step 1, repeats 1, last 1; start at k -> LOAD at k+1; addresses 0..31 on k+2..k+33; done=1 and busy=0 at k+34.
- Step and phase continuity: slot0 = sel 2, step 3, repeats 2, last 1 -> period 1 is 0,3,...,30 (11 samples); period 2 is 1,4,...,31 (11 samples); done follows.
- Multi-segment: slot0 = sel 0, step 4, rep 1; slot1 = sel 3, step 2, rep 1, last 1 -> 8 samples with tbl_sel 0, then 1 LOAD gap cycle with sample_valid=0 and seg_idx=1, then 16 samples with tbl_sel 3, then done.
- Graceful stop: pulse stop at tbl_addr=10 in a step-1 segment with repeats 5 -> playback continues through 31, then IDLE and done. A start in the same cycle as stop in IDLE has no effect.
- Loop and config lockout: loop=1, single segment with last=1 -> after the carry at address 31, LOAD, then a restart at 0 with no done pulse. A cfg_we during RUN leaves the slot unchanged when read back on the next pass.
